// File: rtl/motor_cmd_pkg.sv
// Shared types and constants for the motor command sequencer: command modes,
// commutation-controller codes, broadcast index and per-channel state encoding.
package motor_cmd_pkg;

    typedef enum logic [1:0] {
        MODE_CW     = 2'b00,
        MODE_CCW    = 2'b01,
        MODE_BRK_HI = 2'b10,
        MODE_BRK_LO = 2'b11
    } mode_e;

    localparam logic [2:0] CC_COAST  = 3'b000;
    localparam logic [2:0] CC_CW     = 3'b010;
    localparam logic [2:0] CC_CCW    = 3'b100;
    localparam logic [2:0] CC_BRK_HI = 3'b110;
    localparam logic [2:0] CC_BRK_LO = 3'b001;

    localparam logic [5:0] BCAST_IDX = 6'h3F;

    typedef enum logic [2:0] {
        ST_COAST    = 3'd0,
        ST_CW       = 3'd1,
        ST_CCW      = 3'd2,
        ST_BRK_HI   = 3'd3,
        ST_BRK_LO   = 3'd4,
        ST_DEADTIME = 3'd5
    } chan_state_e;

    // Dead-time is a low-side brake as far as the commutation controller is concerned.
    function automatic logic [2:0] state_to_cc(input chan_state_e st);
        logic [2:0] cc;
        case (st)
            ST_CW:       cc = CC_CW;
            ST_CCW:      cc = CC_CCW;
            ST_BRK_HI:   cc = CC_BRK_HI;
            ST_BRK_LO:   cc = CC_BRK_LO;
            ST_DEADTIME: cc = CC_BRK_LO;
            default:     cc = CC_COAST;
        endcase
        return cc;
    endfunction

endpackage

// File: rtl/motor_chan_fsm.sv
// One motor channel: mode state machine with dead-time braking on direction
// reversal, pending-direction register and saturating dead-time counter.
module motor_chan_fsm
    import motor_cmd_pkg::*;
#(
    parameter int DEADTIME_CYC = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  mode_e      cmd_mode,
    input  logic       force_brake,
    output logic [2:0] cc,
    output logic       busy
);

    localparam int CNT_W = $clog2(DEADTIME_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEADTIME_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    chan_state_e      state_q, state_d;
    logic             pend_ccw_q, pend_ccw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       cc_q, cc_d;
    logic             busy_q, busy_d;
    logic             want_ccw_s;
    logic             restart_s;

    // Next-state, pending direction and dead-time counter.
    always_comb begin
        state_d    = state_q;
        pend_ccw_d = pend_ccw_q;
        cnt_d      = cnt_q;
        want_ccw_s = (cmd_mode == MODE_CCW);
        restart_s  = 1'b0;

        if (force_brake) begin
            state_d = ST_BRK_LO;
            cnt_d   = '0;
        end else if (cmd_valid) begin
            case (cmd_mode)
                MODE_BRK_HI: begin
                    state_d = ST_BRK_HI;
                    cnt_d   = '0;
                end
                MODE_BRK_LO: begin
                    state_d = ST_BRK_LO;
                    cnt_d   = '0;
                end
                MODE_CW, MODE_CCW: begin
                    if (state_q == ST_DEADTIME) begin
                        // Only a change of mind restarts the interval.
                        if (want_ccw_s != pend_ccw_q) begin
                            pend_ccw_d = want_ccw_s;
                            cnt_d      = '0;
                            restart_s  = 1'b1;
                        end else begin
                            restart_s  = 1'b0;
                        end
                    end else if ((state_q == ST_CW && want_ccw_s) ||
                                 (state_q == ST_CCW && !want_ccw_s)) begin
                        state_d    = ST_DEADTIME;
                        pend_ccw_d = want_ccw_s;
                        cnt_d      = '0;
                    end else begin
                        state_d = want_ccw_s ? ST_CCW : ST_CW;
                    end
                end
                default: state_d = state_q;
            endcase
        end else begin
            state_d = state_q;
        end

        // Exit happens on the last count, so the counter never passes terminal.
        if (state_q == ST_DEADTIME && state_d == ST_DEADTIME && !restart_s) begin
            if (cnt_q >= CNT_LAST) begin
                state_d = pend_ccw_q ? ST_CCW : ST_CW;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_d;
        end

        cc_d   = state_to_cc(state_d);
        busy_d = (state_d == ST_DEADTIME);
    end

    // Channel state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_COAST;
            pend_ccw_q <= 1'b0;
            cnt_q      <= '0;
            cc_q       <= CC_COAST;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_ccw_q <= pend_ccw_d;
            cnt_q      <= cnt_d;
            cc_q       <= cc_d;
            busy_q     <= busy_d;
        end
    end

    assign cc   = cc_q;
    assign busy = busy_q;

endmodule

// File: rtl/motor_cmd_sequencer.sv
// UART command byte decoder driving NUM_MOTORS channel state machines.
// Optional link-loss watchdog enabled with `define MOTOR_WDOG_EN.
module motor_cmd_sequencer
    import motor_cmd_pkg::*;
#(
    parameter int NUM_MOTORS   = 4,
    parameter int DEADTIME_CYC = 1000,
    parameter int WDOG_CYC     = 1000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [3*NUM_MOTORS-1:0] cc_out,
    output logic [NUM_MOTORS-1:0]   busy,
    output logic                    cmd_err,
    output logic                    wdog_trip
);

    if (NUM_MOTORS < 1 || NUM_MOTORS > 63 || DEADTIME_CYC < 1 || WDOG_CYC < 1) begin : g_bad_param
        $error("motor_cmd_sequencer: parameter out of range");
    end

    logic [5:0]            idx_s;
    mode_e                 mode_s;
    logic                  bcast_s;
    logic                  idx_ok_s;
    logic [NUM_MOTORS-1:0] sel_s;
    logic                  force_brake_s;
    logic                  cmd_err_q, cmd_err_d;

    assign idx_s    = rx_data[7:2];
    assign mode_s   = mode_e'(rx_data[1:0]);
    assign bcast_s  = (idx_s == BCAST_IDX);
    assign idx_ok_s = (idx_s < 6'(NUM_MOTORS));

    // Unknown-address detection.
    always_comb begin
        cmd_err_d = rx_valid && !bcast_s && !idx_ok_s;
    end

    // Command error pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_err_q <= 1'b0;
        end else begin
            cmd_err_q <= cmd_err_d;
        end
    end

    assign cmd_err = cmd_err_q;

    for (genvar k = 0; k < NUM_MOTORS; k++) begin : g_chan
        assign sel_s[k] = rx_valid && (bcast_s || idx_s == 6'(k));

        motor_chan_fsm #(
            .DEADTIME_CYC(DEADTIME_CYC)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .cmd_valid  (sel_s[k]),
            .cmd_mode   (mode_s),
            .force_brake(force_brake_s),
            .cc         (cc_out[3*k +: 3]),
            .busy       (busy[k])
        );
    end

`ifdef MOTOR_WDOG_EN
    localparam int WD_W = $clog2(WDOG_CYC + 1);
    localparam logic [WD_W-1:0] WD_TERM = WD_W'(WDOG_CYC);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

    logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
    logic            wdog_trip_q, wdog_trip_d;

    // Idle-cycle counter; any received byte restarts it and beats a same-cycle expiry.
    always_comb begin
        if (rx_valid) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WD_TERM) begin
            wd_cnt_d = wd_cnt_q + WD_ONE;
        end else begin
            wd_cnt_d = wd_cnt_q;
        end
        wdog_trip_d   = !rx_valid && (wd_cnt_d == WD_TERM);
        force_brake_s = wdog_trip_d;
    end

    // Watchdog counter and trip flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt_q    <= '0;
            wdog_trip_q <= 1'b0;
        end else begin
            wd_cnt_q    <= wd_cnt_d;
            wdog_trip_q <= wdog_trip_d;
        end
    end

    assign wdog_trip = wdog_trip_q;
`else
    assign force_brake_s = 1'b0;
    assign wdog_trip     = 1'b0;
`endif

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Directed scoreboard bench for motor_cmd_sequencer (watchdog section under MOTOR_WDOG_EN).
`timescale 1ns/1ps
module tb_motor_cmd_sequencer;

    localparam int NM = 4;
    localparam int DT = 8;
    localparam int WD = 50;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [7:0]      rx_data = 8'h00;
    logic            rx_valid = 1'b0;
    logic [3*NM-1:0] cc_out;
    logic [NM-1:0]   busy;
    logic            cmd_err;
    logic            wdog_trip;

    motor_cmd_sequencer #(
        .NUM_MOTORS  (NM),
        .DEADTIME_CYC(DT),
        .WDOG_CYC    (WD)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .cc_out   (cc_out),
        .busy     (busy),
        .cmd_err  (cmd_err),
        .wdog_trip(wdog_trip)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int              cyc;
        logic [3*NM-1:0] cc;
        logic [NM-1:0]   busy;
        logic            err;
        logic            wd;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    cyc = 0;
    int    n_cmp = 0;
    int    n_err = 0;

    logic [3*NM-1:0] exp_cc = '0;
    logic [NM-1:0]   exp_busy = '0;
    logic            exp_err = 1'b0;
    logic            exp_wd = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic compare(input string tag, input exp_t e);
        n_cmp++;
        if (cc_out !== e.cc || busy !== e.busy || cmd_err !== e.err || wdog_trip !== e.wd) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got cc=%b busy=%b err=%b wd=%b, want cc=%b busy=%b err=%b wd=%b",
                     tag, cyc, cc_out, busy, cmd_err, wdog_trip, e.cc, e.busy, e.err, e.wd);
        end
    endtask

    // Drive one cycle of stimulus and queue the response expected after the next edge.
    task automatic tick(input logic v, input logic [7:0] b, input string tag);
        exp_t e;
        rx_valid = v;
        rx_data  = b;
        e.cyc  = cyc + 1;
        e.cc   = exp_cc;
        e.busy = exp_busy;
        e.err  = exp_err;
        e.wd   = exp_wd;
        sb_q.push_back(e);
        tag_q.push_back(tag);
        exp_err = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, tag);
    endtask

    // Monitor: compare every queued expectation in the cycle it targets.
    initial begin
        exp_t  me;
        string mt;
        forever begin
            @(negedge clk);
            while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
                me = sb_q.pop_front();
                mt = tag_q.pop_front();
                if (me.cyc < cyc) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL %s: expectation for cyc %0d missed, now %0d", mt, me.cyc, cyc);
                end else begin
                    compare(mt, me);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, compared=%0d", n_cmp);
        $fatal(1, "timeout");
    end

    initial begin
        exp_t r;
        repeat (3) @(negedge clk);
        r = '0;
        r.cyc = cyc;
        compare("reset", r);
        rst = 1'b0;
        tick(1'b0, 8'h00, "post_rst");

        // Motor 0 high-side brake, others stay coasting
        exp_cc[2:0] = 3'b110;
        tick(1'b1, 8'h02, "m0_brkhi");
        tick(1'b0, 8'h00, "m0_hold");

        // Motor 1 CW then CCW: dead-time of exactly DT cycles
        exp_cc[5:3] = 3'b010;
        tick(1'b1, 8'h04, "m1_cw");
        exp_cc[5:3] = 3'b001;
        exp_busy[1] = 1'b1;
        tick(1'b1, 8'h05, "m1_rev");
        tick(1'b0, 8'h00, "m1_dt");
        tick(1'b1, 8'h05, "m1_dt_same");
        idle(DT - 3, "m1_dt");
        exp_cc[5:3] = 3'b100;
        exp_busy[1] = 1'b0;
        tick(1'b0, 8'h00, "m1_ccw");
        tick(1'b1, 8'h05, "m1_repeat");

        // Abort dead-time with BRK_LO
        exp_cc[5:3] = 3'b001;
        exp_busy[1] = 1'b1;
        tick(1'b1, 8'h04, "m1_rev2");
        idle(3, "m1_dt2");
        exp_busy[1] = 1'b0;
        tick(1'b1, 8'h07, "m1_abort");
        idle(DT, "m1_brklo");

        // Opposite direction during dead-time restarts the interval
        exp_cc[5:3] = 3'b010;
        tick(1'b1, 8'h04, "m1_cw_direct");
        exp_cc[5:3] = 3'b001;
        exp_busy[1] = 1'b1;
        tick(1'b1, 8'h05, "m1_rev3");
        idle(3, "m1_dt3");
        tick(1'b1, 8'h04, "m1_restart");
        idle(DT - 1, "m1_dt_rst");
        exp_cc[5:3] = 3'b010;
        exp_busy[1] = 1'b0;
        tick(1'b0, 8'h00, "m1_cw_late");

        // Broadcast CW then broadcast CCW reversal on all channels
        exp_cc = {4{3'b010}};
        tick(1'b1, 8'hFC, "bcast_cw");
        exp_cc   = {4{3'b001}};
        exp_busy = 4'hF;
        tick(1'b1, 8'hFD, "bcast_rev");
        idle(DT - 1, "bcast_dt");
        exp_cc   = {4{3'b100}};
        exp_busy = 4'h0;
        tick(1'b0, 8'h00, "bcast_ccw");

        // Nonexistent motors, then last valid motor
        exp_err = 1'b1;
        tick(1'b1, 8'h10, "bad_idx4");
        tick(1'b0, 8'h00, "err_clear");
        exp_err = 1'b1;
        tick(1'b1, 8'hF9, "bad_idx62");
        tick(1'b0, 8'h00, "err_clear2");
        exp_cc[11:9] = 3'b001;
        tick(1'b1, 8'h0F, "m3_brklo");

        // Asynchronous reset in the middle of motor 2 dead-time
        exp_cc[8:6] = 3'b001;
        exp_busy[2] = 1'b1;
        tick(1'b1, 8'h08, "m2_rev");
        idle(2, "m2_dt");
        #2 rst = 1'b1;
        #1;
        r = '0;
        r.cyc = cyc;
        compare("rst_async", r);
        exp_cc   = '0;
        exp_busy = '0;
        @(negedge clk);
        tick(1'b0, 8'h00, "rst_hold");
        rst = 1'b0;
        exp_cc[8:6] = 3'b100;
        tick(1'b1, 8'h09, "m2_ccw_nodt");
        tick(1'b0, 8'h00, "m2_hold");

`ifdef MOTOR_WDOG_EN
        // Link loss forces every channel to BRK_LO
        exp_cc[8:6] = 3'b110;
        tick(1'b1, 8'h0A, "wd_start");
        idle(WD - 1, "wd_quiet");
        exp_cc = {4{3'b001}};
        exp_wd = 1'b1;
        tick(1'b0, 8'h00, "wd_trip");
        idle(3, "wd_held");
        exp_wd      = 1'b0;
        exp_cc[2:0] = 3'b010;
        tick(1'b1, 8'h00, "wd_clear");
        idle(WD - 1, "wd_quiet2");
        exp_cc[2:0] = 3'b110;
        tick(1'b1, 8'h02, "wd_expiry_rx");
        idle(5, "wd_no_trip");
`endif

        tick(1'b0, 8'h00, "final");
        repeat (2) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/motor_cmd_sequencer.md
Name: motor_cmd_sequencer

Overview:
Parametrised successor to the 8-to-12 UART command diverger. Accepts command bytes from the UART receiver and drives a 3-bit commutation-controller mode code for each of NUM_MOTORS motors. Unlike the combinational diverger, it is fully registered and adds:
- per-motor addressing and broadcast
- enforced dead-time braking on every direction reversal
- command-error reporting
- optional link-loss watchdog
It sits between the UART receiver and the per-motor commutation controllers.

Parameters:
- NUM_MOTORS, 4, number of motor channels (1..63).
- DEADTIME_CYC, 1000, clk cycles of low-side brake inserted on a CW<->CCW reversal (>=1).
- WDOG_CYC, 1000000, clk cycles without a valid byte before a watchdog trip (used only with MOTOR_WDOG_EN).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- rx_data, input, 8, command byte from the UART receiver.
- rx_valid, input, 1, single-cycle strobe; rx_data is valid in this cycle.
- cc_out, output, 3*NUM_MOTORS, mode code for the commutation controllers; motor k uses bits [3k+2:3k].
- busy, output, NUM_MOTORS, bit k high while motor k is in DEADTIME.
- cmd_err, output, 1, one-cycle pulse when a byte addresses a nonexistent motor.
- wdog_trip, output, 1, level; high while the watchdog-forced brake is active (held 0 without MOTOR_WDOG_EN).

Behaviour:
- Clock and reset: one clock domain, clk. rst is asynchronous, active-high. All state is reset asynchronously.
- Reset values:
  - All channels enter COAST, so cc_out = all zeros.
  - busy = 0, cmd_err = 0, wdog_trip = 0.
  - Deadtime and watchdog counters = 0.
- Byte format: rx_data[7:2] is the motor index; rx_data[1:0] is the mode: 00 CW, 01 CCW, 10 BRK_HI, 11 BRK_LO.
- Addressing:
  - Index 6'h3F is broadcast; the command applies to every channel in the same cycle.
  - Index >= NUM_MOTORS and not 3F: the byte is ignored and cmd_err pulses in the following cycle.
- Mode codes (registered outputs): COAST 000, CW 010, CCW 100, BRK_HI 110, BRK_LO 001.
- Latency: a byte accepted in cycle N changes cc_out in cycle N+1.
- Per-channel state machine, states COAST, CW, CCW, BRK_HI, BRK_LO, DEADTIME:
  - From any state except DEADTIME, a command goes directly to its target state, except a reversal CW->CCW or CCW->CW.
  - A reversal enters DEADTIME:
    - output is BRK_LO for exactly DEADTIME_CYC cycles;
    - the requested direction is stored as the pending direction;
    - the channel then enters that direction;
    - busy=1 for the whole DEADTIME interval.
  - A command repeating the current state causes no change and no counter restart.
  - COAST, BRK_HI or BRK_LO to CW/CCW: direct, no dead-time. A brake already decelerates the motor.
- Command arriving while in DEADTIME:
  - BRK_HI or BRK_LO: DEADTIME is aborted and the brake state is entered next cycle.
  - CW/CCW equal to the pending direction: ignored, counter continues.
  - The opposite direction: the pending direction is overwritten and the counter restarts from 0.
- Deadtime counter: width $clog2(DEADTIME_CYC+1); no wrap-around, it saturates at terminal count.
- Reset mid-DEADTIME: the channel goes to COAST immediately; the pending direction is discarded.

Optional Feature:
- Macro: MOTOR_WDOG_EN.
- When defined:
  - A $clog2(WDOG_CYC+1)-bit counter counts cycles since the last rx_valid, valid address or not.
  - On reaching WDOG_CYC, every channel is forced to BRK_LO: pending DEADTIME is aborted, busy is cleared, and wdog_trip=1.
  - The counter holds at terminal count.
  - The next rx_valid clears wdog_trip and resets the counter, and its byte is decoded normally in the same cycle.
  - rx_valid in the expiry cycle wins: no trip occurs.
- When undefined: no counter logic; wdog_trip is tied to 0.

Decomposition:
- Package motor_cmd_pkg holds:
  - the mode enum (CW, CCW, BRK_HI, BRK_LO);
  - the 3-bit CC code constants (COAST, CW, CCW, BRK_HI, BRK_LO);
  - the broadcast index constant 6'h3F;
  - the channel-state typedef.
- Sub-module motor_chan_fsm, one instance per channel via generate. It contains the state machine, deadtime counter and pending-direction register. Its ports are clk, rst, cmd_valid, cmd_mode, force_brake, cc and busy.
- The top level holds address decode, cmd_err generation and the watchdog.

Test Plan:
- Reset release, then byte 8'h02 (motor 0, BRK_HI) in cycle N -> cc_out[2:0]=110 in cycle N+1; all other channels stay 000.
- Motor 1: byte 8'h04 (CW), then 8'h05 (CCW) -> cc_out[5:3]=001 and busy[1]=1 for exactly DEADTIME_CYC cycles, then 100 and busy[1]=0.
- During motor 1 DEADTIME, send 8'h07 (BRK_LO) -> DEADTIME aborted; cc_out[5:3]=001 and busy[1]=0 next cycle. Separately, send 8'h04 during DEADTIME -> counter restarts; CW appears DEADTIME_CYC cycles after that byte.
- Byte 8'hFC (broadcast CW) -> all channels 010 next cycle. Byte 8'h10 with NUM_MOTORS=4 -> cmd_err pulses for 1 cycle; cc_out unchanged.
- MOTOR_WDOG_EN, WDOG_CYC=50: no bytes for 50 cycles -> all channels 001, wdog_trip=1. Byte 8'h00 then clears wdog_trip and sets motor 0 to CW next cycle. Byte in the expiry cycle -> no trip.
- Assert rst mid-DEADTIME -> cc_out=0 and busy=0 immediately (asynchronous). After release, a CCW command takes effect with no dead-time.
